// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The fetch queue stores {addr, data} pairs; NOP is what decode sees when nothing is valid.
package ifu_pkg;

  localparam logic [31:0] INST_NOP   = 32'h0000_0013;
  localparam logic [31:0] INST_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous fetch queue of DEPTH {addr,data} entries with flush.
// The head is read combinationally so decode sees a word the cycle after it is written.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full queue is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  no_overflow_a : assert property (@(posedge clk) disable iff (rst)
    !(push_i && full_o && !pop_i));

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC generation, credit-limited memory requests,
// response dropping after redirects, and a fetch queue feeding decode.
module ifu
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic [31:0] ins_o,
  output logic [31:0] ins_addr_o,
  output logic        ins_valid_o,
  input  logic        ins_ready_i
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  fetch_entry_t  fifo_head, fifo_push_data;
  logic [CW:0]   credit_used;
  logic          credit_ok, grant, resp_keep, pop;
  logic [31:0]   jump_target;

  // Queued words plus words still in flight may never exceed the queue size.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign credit_ok   = credit_used < (CW + 1)'(DEPTH);

  assign imem_req_o  = credit_ok & ~hold_flag_i & ~jump_en_i & ~rst;
  assign imem_addr_o = pc_q;
  assign grant       = imem_req_o & imem_gnt_i;

  assign resp_keep   = imem_rvalid_i & ~jump_en_i & (drop_cnt_q == '0);
  assign jump_target = align_word(jump_addr_i);

  assign ins_valid_o = ~fifo_empty & ~hold_flag_i & ~jump_en_i & ~rst;
  assign ins_o       = ins_valid_o ? fifo_head.data : INST_NOP;
  assign ins_addr_o  = ins_valid_o ? fifo_head.addr : 32'h0;
  assign pop         = ins_valid_o & ins_ready_i;

  assign fifo_push_data = '{addr: resp_pc_q, data: imem_rdata_i};

  ifu_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (resp_keep),
    .push_data_i (fifo_push_data),
    .pop_i       (pop),
    .flush_i     (jump_en_i),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // A redirect turns every response still owed by memory into one to be dropped.
  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid_i);
    if (jump_en_i) begin
      pc_d       = jump_target;
      resp_pc_d  = jump_target;
      drop_cnt_d = outstanding_q - CW'(imem_rvalid_i);
    end else begin
      if (grant) begin
        pc_d = pc_q + INST_BYTES;
      end
      if (resp_keep) begin
        resp_pc_d = resp_pc_q + INST_BYTES;
      end
      if (imem_rvalid_i && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_ADDR;
      resp_pc_q     <= RESET_ADDR;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  full_means_idle_a : assert property (@(posedge clk) disable iff (rst)
    fifo_full |-> (outstanding_q == '0));

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: a randomized memory and a queue-based reference
// model of fetched words, in-flight requests and redirect staleness.
module tb_ifu;

  localparam int          DEPTH      = 2;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_i;
  logic [31:0] ins_o;
  logic [31:0] ins_addr_o;
  logic        ins_valid_o;
  logic        ins_ready_i;

  ifu #(
    .DEPTH      (DEPTH),
    .RESET_ADDR (RESET_ADDR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .jump_en_i     (jump_en_i),
    .jump_addr_i   (jump_addr_i),
    .hold_flag_i   (hold_flag_i),
    .ins_o         (ins_o),
    .ins_addr_o    (ins_addr_o),
    .ins_valid_o   (ins_valid_o),
    .ins_ready_i   (ins_ready_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } flight_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } word_t;

  flight_t     inflight[$];
  word_t       expq[$];
  logic [31:0] m_pc;
  int          cyc;
  int          last_due;
  int          checks;
  int          errors;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    expq.delete();
    inflight.delete();
    m_pc     = RESET_ADDR;
    last_due = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst           = 1'b1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    jump_en_i     = 1'b0;
    jump_addr_i   = 32'h0;
    hold_flag_i   = 1'b0;
    ins_ready_i   = 1'b0;
    #1;
    checkOutput("rst_req",   {31'b0, imem_req_o},  32'h0);
    checkOutput("rst_valid", {31'b0, ins_valid_o}, 32'h0);
    checkOutput("rst_ins",   ins_o,                NOP);
    checkOutput("rst_addr",  ins_addr_o,           32'h0);
    modelReset();
    @(posedge clk);
    cyc++;
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, then advance the model.
  task automatic applyStimulus(input bit jmp, input logic [31:0] jaddr, input bit hld,
                               input int rdy_pct, input int gnt_pct, input int max_lat);
    bit      resp, credit, exp_req, exp_valid, pop;
    int      due;
    flight_t f;
    @(negedge clk);
    rst         = 1'b0;
    jump_en_i   = jmp;
    jump_addr_i = jaddr;
    hold_flag_i = hld;
    ins_ready_i = ($urandom_range(99) < rdy_pct);
    imem_gnt_i  = ($urandom_range(99) < gnt_pct);
    resp        = (inflight.size() > 0) && (inflight[0].due <= cyc);
    imem_rvalid_i = resp;
    imem_rdata_i  = resp ? word_of(inflight[0].addr) : $urandom;
    credit    = (expq.size() + inflight.size()) < DEPTH;
    exp_req   = credit && !hld && !jmp;
    exp_valid = (expq.size() > 0) && !hld && !jmp;
    #1;
    checkOutput("imem_req",  {31'b0, imem_req_o},  {31'b0, exp_req});
    checkOutput("imem_addr", imem_addr_o,          m_pc);
    checkOutput("ins_valid", {31'b0, ins_valid_o}, {31'b0, exp_valid});
    checkOutput("ins_o",     ins_o,                exp_valid ? expq[0].data : NOP);
    checkOutput("ins_addr",  ins_addr_o,           exp_valid ? expq[0].addr : 32'h0);
    pop = exp_valid && ins_ready_i;
    if (jmp) begin
      expq.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      m_pc = jaddr & 32'hFFFF_FFFC;
    end else begin
      if (pop) void'(expq.pop_front());
      if (exp_req && imem_gnt_i) begin
        due = cyc + $urandom_range(max_lat, 1);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        inflight.push_back('{addr: m_pc, due: due, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    if (resp) begin
      f = inflight.pop_front();
      if (!f.stale) expq.push_back('{addr: f.addr, data: word_of(f.addr)});
    end
    @(posedge clk);
    cyc++;
  endtask

  // Waits for a cycle where a response lands while a word is poppable, then redirects there.
  task automatic jumpOnResponse(input logic [31:0] jaddr, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (inflight.size() > 0 && inflight[0].due <= cyc && expq.size() > 0) begin
        applyStimulus(1'b1, jaddr, 1'b0, 100, 100, 2);
        done = 1'b1;
      end else begin
        applyStimulus(1'b0, 32'h0, 1'b0, 40, 100, 2);
      end
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("[TB] FAIL jump_on_resp: observed=0 expected=1");
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    cyc           = 0;
    rst           = 1'b1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    jump_en_i     = 1'b0;
    jump_addr_i   = 32'h0;
    hold_flag_i   = 1'b0;
    ins_ready_i   = 1'b0;
    modelReset();

    doReset();
    $display("[TB] streaming");
    repeat (12) applyStimulus(1'b0, 32'h0, 1'b0, 100, 100, 1);

    $display("[TB] backpressure");
    repeat (5) applyStimulus(1'b0, 32'h0, 1'b0, 0, 100, 1);
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b0, 100, 100, 1);

    $display("[TB] redirect with requests in flight");
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 100, 100, 3);
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 100, 100, 3);
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b0, 100, 100, 3);

    $display("[TB] redirect coincident with response and pop");
    jumpOnResponse(32'h0000_0200, 60);
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b0, 100, 100, 2);

    $display("[TB] hold");
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b0, 0, 100, 3);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 100, 100, 3);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b0, 100, 100, 3);

    $display("[TB] misaligned redirect and address wrap");
    applyStimulus(1'b1, 32'hFFFF_FFFE, 1'b0, 100, 100, 1);
    #1;
    checkOutput("wrap_pc", imem_addr_o, 32'hFFFF_FFFC);
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b0, 100, 100, 1);

    $display("[TB] random soak");
    repeat (400) applyStimulus($urandom_range(99) < 5, $urandom, $urandom_range(99) < 10, 70, 70, 4);

    $display("[TB] mid-stream reset");
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b0, 50, 100, 2);
    doReset();
    #1;
    checkOutput("post_rst_ins",  ins_o,       NOP);
    checkOutput("post_rst_addr", ins_addr_o,  32'h0);
    checkOutput("post_rst_pc",   imem_addr_o, RESET_ADDR);
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b0, 100, 100, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
